ei_min_queue: RTL and testbench
===============================

Name: ei_min_queue

Overview:
- Consumer end of the local-minimum trigger interface. Captures each minimum event (sample index plus minimum value) from the minimum detector into a show-ahead FIFO.
- Presents the events to the envelope/interpolation stage over a valid/ready handshake.
- Suppresses duplicate triggers for the same sample index and reports overflow.
- Sits between the extremum detector and the spline/envelope builder in the EMD sifting pipeline.

Parameters:
- DEPTH, 16, FIFO entries; power of two, min 2.
- AW, 4, pointer width, log2(DEPTH).
- TW, 16, width of sample index (Time).
- DW, 16, width of signed sample value.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_n  in  1  asynchronous active-low reset.
- Time  in  TW  index of current middle sample.
- Val  in  DW  signed middle-sample value (the candidate minimum).
- Trg  in  1  minimum-detected strobe, sampled on rising CLK.
- Clr  in  1  synchronous flush at start of a new sifting pass.
- Rd_ready  in  1  downstream accepts head entry.
- Rd_valid  out  1  head entry valid.
- Rd_time  out  TW  head entry index.
- Rd_val  out  DW  head entry value, signed.
- Count  out  AW+1  entries held, 0..DEPTH.
- Full  out  1  Count==DEPTH.
- Empty  out  1  Count==0.
- Ovf  out  1  sticky: a trigger was lost or overwritten.

Behaviour:
- Reset (RST_n low, async): Rd_valid=0, Rd_time=0, Rd_val=0, Count=0, Full=0, Empty=1, Ovf=0. Pointers=0, last-index register=0, last_vld=0. Storage contents are don't-care.
- Write request at a rising edge requires both conditions:
  - Trg=1.
  - NOT(last_vld=1 and Time==last_time).
- Duplicate suppression: Trg held for several cycles with unchanged Time produces one entry. On each accepted write, last_time<=Time and last_vld<=1.
- Write: {Time,Val} is stored at the write pointer; the pointer increments modulo DEPTH with natural wrap.
- Read: occurs on a rising edge with Rd_valid=1 and Rd_ready=1; the read pointer increments modulo DEPTH.
- Show-ahead: Rd_time/Rd_val always reflect the head entry when Rd_valid=1. When Rd_valid=0 they hold their last value.
- Latency: an entry written at edge N into an empty queue gives Rd_valid=1 after edge N, so it is consumable at edge N+1. No combinational path from Trg to Rd_valid.
- Count, Full, Empty are registered and updated at the same edge as the pointers:
  - write only: +1
  - read only: -1
  - both: unchanged
- Full, no read: a new write is dropped; Ovf<=1; contents are unchanged.
- Full with read at the same edge: the write is accepted; no overflow.
- Empty with write: Rd_valid was 0 at that edge, so no read occurs that edge.
- Clr=1 (synchronous, highest priority over read/write):
  - Pointers=0, Count=0, Empty=1, Full=0, Rd_valid=0, Ovf=0, last_vld=0.
  - A Trg at the same edge is discarded.
- RST_n asserted mid-transfer: immediate return to reset values; in-flight entries are lost.
- Signed value is stored bit-exact; no arithmetic is performed on Val.

Optional Feature:
- Macro EI_MIN_QUEUE_DROP_OLDEST_EN.
- Defined: a write to a full queue with no read overwrites the oldest entry.
  - Both pointers advance and Count stays at DEPTH.
  - The new head is the next-oldest entry; Ovf<=1.
- Not defined: the newest trigger is dropped as described above.
- All other behaviour is identical in both builds.

Test Plan:
1. Reset, then Trg=1 at Time=3, Val=-5 for one edge with Rd_ready=0 -> after that edge Rd_valid=1, Rd_time=3, Rd_val=-5, Count=1, Empty=0.
2. Trg held 4 edges with Time=20, Val=7 -> exactly one entry; Count=1. Time then changes to 21 with Trg=1 -> Count=2.
3. Fill with Time=1..16 (DEPTH=16), Rd_ready=0, then Trg at Time=17:
   - without macro: Count=16, Ovf=1, head Time=1.
   - with EI_MIN_QUEUE_DROP_OLDEST_EN: head Time=2, tail Time=17, Ovf=1.
4. Full queue, Trg at Time=30 with Rd_ready=1 at the same edge -> Count stays 16, Ovf=0. Draining all 16 yields Time=2..16 then 30, in order, with pointer wrap.
5. Queue holding 5 entries; Clr=1 together with Trg=1, Rd_ready=1 -> next cycle Count=0, Empty=1, Rd_valid=0, Ovf=0. A Trg at a previously used Time is accepted afterwards.
6. Assert RST_n=0 between clock edges while Count=3 -> outputs reach reset values without waiting for CLK.

Source files
------------

// File: rtl/ei_min_queue.sv
// Show-ahead event FIFO for local-minimum triggers with duplicate suppression and sticky overflow.
// Optional EI_MIN_QUEUE_DROP_OLDEST_EN: a write to a full queue overwrites the oldest entry instead of being dropped.
module ei_min_queue #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int TW    = 16,
    parameter int DW    = 16
) (
    input  logic          CLK,
    input  logic          RST_n,
    input  logic [TW-1:0] Time,
    input  logic [DW-1:0] Val,
    input  logic          Trg,
    input  logic          Clr,
    input  logic          Rd_ready,
    output logic          Rd_valid,
    output logic [TW-1:0] Rd_time,
    output logic [DW-1:0] Rd_val,
    output logic [AW:0]   Count,
    output logic          Full,
    output logic          Empty,
    output logic          Ovf
);

    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

    logic [TW+DW-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full_q, full_d, empty_q, empty_d;
    logic          rd_valid_q, rd_valid_d, ovf_q, ovf_d;
    logic [TW-1:0] rd_time_q, rd_time_d, last_time_q, last_time_d;
    logic [DW-1:0] rd_val_q, rd_val_d;
    logic          last_vld_q, last_vld_d;

    logic dup_s, wr_req_s, rd_en_s, wr_en_s, rd_adv_s, ovf_set_s, mem_we_s;

    // Handshake qualification: duplicate filter, read strobe, full-queue policy.
    always_comb begin
        dup_s    = last_vld_q && (Time == last_time_q);
        wr_req_s = Trg && !dup_s;
        rd_en_s  = rd_valid_q && Rd_ready;
`ifdef EI_MIN_QUEUE_DROP_OLDEST_EN
        wr_en_s   = wr_req_s;
        ovf_set_s = wr_req_s && full_q && !rd_en_s;
        rd_adv_s  = rd_en_s || ovf_set_s;
`else
        wr_en_s   = wr_req_s && (!full_q || rd_en_s);
        ovf_set_s = wr_req_s && full_q && !rd_en_s;
        rd_adv_s  = rd_en_s;
`endif
        mem_we_s = wr_en_s && !Clr;
    end

    // Next-state: flush has priority; otherwise advance pointers and preload the head.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        full_d      = full_q;
        empty_d     = empty_q;
        rd_valid_d  = rd_valid_q;
        rd_time_d   = rd_time_q;
        rd_val_d    = rd_val_q;
        ovf_d       = ovf_q;
        last_time_d = last_time_q;
        last_vld_d  = last_vld_q;
        if (Clr) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            full_d     = 1'b0;
            empty_d    = 1'b1;
            rd_valid_d = 1'b0;
            ovf_d      = 1'b0;
            last_vld_d = 1'b0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_d    = wr_ptr_q + PTR_ONE;
                last_time_d = Time;
                last_vld_d  = 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (rd_adv_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({wr_en_s, rd_adv_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
            if (ovf_set_s) begin
                ovf_d = 1'b1;
            end else begin
                ovf_d = ovf_q;
            end
            full_d  = (count_d == DEPTH_C);
            empty_d = (count_d == '0);
            // The new head may be the entry being written this very edge.
            if (count_d != '0) begin
                rd_valid_d = 1'b1;
                if (wr_en_s && (rd_ptr_d == wr_ptr_q)) begin
                    rd_time_d = Time;
                    rd_val_d  = Val;
                end else begin
                    {rd_time_d, rd_val_d} = mem_q[rd_ptr_d];
                end
            end else begin
                rd_valid_d = 1'b0;
            end
        end
    end

    // Storage array; contents need no reset.
    always_ff @(posedge CLK) begin
        if (mem_we_s) begin
            mem_q[wr_ptr_q] <= {Time, Val};
        end
    end

    // Control and output registers.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            rd_valid_q  <= 1'b0;
            rd_time_q   <= '0;
            rd_val_q    <= '0;
            ovf_q       <= 1'b0;
            last_time_q <= '0;
            last_vld_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            rd_valid_q  <= rd_valid_d;
            rd_time_q   <= rd_time_d;
            rd_val_q    <= rd_val_d;
            ovf_q       <= ovf_d;
            last_time_q <= last_time_d;
            last_vld_q  <= last_vld_d;
        end
    end

    assign Rd_valid = rd_valid_q;
    assign Rd_time  = rd_time_q;
    assign Rd_val   = rd_val_q;
    assign Count    = count_q;
    assign Full     = full_q;
    assign Empty    = empty_q;
    assign Ovf      = ovf_q;

endmodule

// File: tb/tb_ei_min_queue.sv
// Scoreboard bench for ei_min_queue: stimulus pushes expected {time,val}; a negedge monitor checks every handshake.
module tb_ei_min_queue;

    logic        clk;
    logic        rst_n;
    logic [15:0] time_s;
    logic [15:0] val_s;
    logic        trg;
    logic        clr;
    logic        rd_ready;
    logic        rd_valid;
    logic [15:0] rd_time;
    logic [15:0] rd_val;
    logic [4:0]  count;
    logic        full;
    logic        empty;
    logic        ovf;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q [$];

    ei_min_queue #(.DEPTH(16), .AW(4), .TW(16), .DW(16)) dut (
        .CLK(clk), .RST_n(rst_n), .Time(time_s), .Val(val_s), .Trg(trg), .Clr(clr),
        .Rd_ready(rd_ready), .Rd_valid(rd_valid), .Rd_time(rd_time), .Rd_val(rd_val),
        .Count(count), .Full(full), .Empty(empty), .Ovf(ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_trg(input logic [15:0] t, input logic [15:0] v);
        trg    = 1'b1;
        time_s = t;
        val_s  = v;
        exp_q.push_back({t, v});
        tick();
    endtask

    // Monitor: every accepted read must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && !clr && rd_valid && rd_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read: got %0h/%0h expected none", rd_time, rd_val);
            end else if ({rd_time, rd_val} !== exp_q[0]) begin
                errors++;
                $display("FAIL read_data: got %0h/%0h expected %0h", rd_time, rd_val, exp_q[0]);
                void'(exp_q.pop_front());
            end else begin
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        rst_n = 1'b0; trg = 1'b0; clr = 1'b0; rd_ready = 1'b0;
        time_s = 16'd0; val_s = 16'd0;
        #12;
        chk("rst_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_count", {27'd0, count}, 32'd0);
        chk("rst_empty_full_ovf", {29'd0, empty, full, ovf}, 32'd4);
        chk("rst_data", {rd_time, rd_val}, 32'd0);
        #10 rst_n = 1'b1;

        // 1: single trigger, show-ahead after one edge
        push_trg(16'd3, 16'hFFFB);
        trg = 1'b0;
        chk("t1_valid", {31'd0, rd_valid}, 32'd1);
        chk("t1_head", {rd_time, rd_val}, {16'd3, 16'hFFFB});
        chk("t1_count", {27'd0, count}, 32'd1);
        chk("t1_empty", {31'd0, empty}, 32'd0);
        rd_ready = 1'b1; tick(); rd_ready = 1'b0;
        chk("t1_drained", {27'd0, count, empty}, {27'd0, 5'd0, 1'b1});

        // 2: held trigger with same Time gives one entry
        push_trg(16'd20, 16'd7);
        repeat (3) tick();
        chk("t2_dup_count", {27'd0, count}, 32'd1);
        push_trg(16'd21, 16'd8);
        trg = 1'b0;
        chk("t2_count2", {27'd0, count}, 32'd2);
        rd_ready = 1'b1; repeat (2) tick(); rd_ready = 1'b0;
        chk("t2_drained", {27'd0, count}, 32'd0);

        // 3: fill then overflow
        for (int i = 1; i <= 16; i++) push_trg(16'(i), 16'(100 - 3 * i));
        trg = 1'b0;
        chk("t3_full", {26'd0, count, full}, {26'd0, 5'd16, 1'b1});
        chk("t3_ovf_pre", {31'd0, ovf}, 32'd0);
        trg = 1'b1; time_s = 16'd17; val_s = 16'h8000;
        tick();
        trg = 1'b0;
`ifdef EI_MIN_QUEUE_DROP_OLDEST_EN
        void'(exp_q.pop_front());
        exp_q.push_back({16'd17, 16'h8000});
        chk("t3_head", {16'd0, rd_time}, 32'd2);
`else
        chk("t3_head", {16'd0, rd_time}, 32'd1);
`endif
        chk("t3_count", {27'd0, count}, 32'd16);
        chk("t3_ovf", {31'd0, ovf}, 32'd1);

        // flush with trigger and read pending; sticky Ovf must clear
        clr = 1'b1; trg = 1'b1; time_s = 16'd99; rd_ready = 1'b1;
        tick();
        clr = 1'b0; trg = 1'b0; rd_ready = 1'b0;
        exp_q.delete();
        chk("clr_state", {24'd0, count, empty, rd_valid, ovf}, {24'd0, 5'd0, 1'b1, 1'b0, 1'b0});

        // 4: full queue, simultaneous read and write, then drain across wrap
        for (int i = 1; i <= 16; i++) push_trg(16'(i), 16'(i * 5));
        trg = 1'b1; time_s = 16'd30; val_s = 16'hABCD; rd_ready = 1'b1;
        exp_q.push_back({16'd30, 16'hABCD});
        tick();
        trg = 1'b0;
        chk("t4_count", {27'd0, count}, 32'd16);
        chk("t4_ovf", {31'd0, ovf}, 32'd0);
        chk("t4_head", {16'd0, rd_time}, 32'd2);
        repeat (16) tick();
        rd_ready = 1'b0;
        chk("t4_drained", {26'd0, count, empty}, {26'd0, 5'd0, 1'b1});
        chk("t4_sb_empty", exp_q.size(), 32'd0);

        // 5: Clr beats Trg and read; reused Time accepted afterwards
        for (int i = 40; i <= 44; i++) push_trg(16'(i), 16'(i));
        trg = 1'b0;
        chk("t5_count5", {27'd0, count}, 32'd5);
        clr = 1'b1; trg = 1'b1; time_s = 16'd45; rd_ready = 1'b1;
        tick();
        clr = 1'b0; trg = 1'b0; rd_ready = 1'b0;
        exp_q.delete();
        chk("t5_clr", {24'd0, count, empty, rd_valid, ovf}, {24'd0, 5'd0, 1'b1, 1'b0, 1'b0});
        push_trg(16'd44, 16'h1234);
        trg = 1'b0;
        chk("t5_reuse", {27'd0, count}, 32'd1);
        chk("t5_head", {rd_time, rd_val}, {16'd44, 16'h1234});
        rd_ready = 1'b1; tick(); rd_ready = 1'b0;

        // 6: async reset between edges
        for (int i = 50; i <= 52; i++) push_trg(16'(i), 16'(i));
        trg = 1'b0;
        chk("t6_count3", {27'd0, count}, 32'd3);
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("t6_rst_count", {27'd0, count}, 32'd0);
        chk("t6_rst_flags", {29'd0, empty, full, ovf}, 32'd4);
        chk("t6_rst_out", {15'd0, rd_valid, rd_time}, 32'd0);
        chk("t6_rst_val", {16'd0, rd_val}, 32'd0);
        #3 rst_n = 1'b1;
        push_trg(16'd0, 16'h0001);
        trg = 1'b0;
        chk("t6_after_rst", {27'd0, count}, 32'd1);
        rd_ready = 1'b1; tick(); rd_ready = 1'b0;
        chk("end_sb_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
